// File: rtl/uart_pkg.sv
// Shared definitions for the burst UART transmitter: FSM state encoding
// and parity-type constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Parity type selector values
  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator for one data word.
// Even parity: XOR of all data bits. Odd parity: its inverse.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  par_bit_o
);

  // Reduce the word and invert for odd parity
  always_comb begin
    par_bit_o = (par_typ_i == ODD) ? ~(^data_i) : (^data_i);
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Burst UART transmitter: sends 1..MAX_BYTES frames back to back, one
// serial bit per CLK cycle, word 0 first, data LSB first.
//
// Request handshake: DATA_VALID is the request, BUSY is the inverted
// ready. A burst is taken on a rising CLK edge where DATA_VALID=1,
// BUSY=0 and NUM_BYTES!=0; all burst inputs are captured on that edge
// and ignored until the block returns to IDLE. DONE pulses in the first
// IDLE cycle, where BUSY is already 0, so a request held in that cycle
// is taken on the following edge.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BYTES  = 2
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [MAX_BYTES*DATA_WIDTH-1:0]   P_DATA,
  input  logic [$clog2(MAX_BYTES+1)-1:0]    NUM_BYTES,
  input  logic                              DATA_VALID,
  input  logic                              PAR_EN,
  input  logic                              PAR_TYP,
  input  logic                              STOP2,
  output logic                              TX_OUT,
  output logic                              BUSY,
  output logic                              DONE,
  output logic [2:0]                        STATE_DBG
);

  localparam int BW  = $clog2(DATA_WIDTH);
  localparam int FW  = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int NBW = $clog2(MAX_BYTES+1);
  localparam int PW  = MAX_BYTES*DATA_WIDTH;

  uart_state_e           state_q, state_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [FW-1:0]         frm_q, frm_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [PW-1:0]         data_q, data_d;
  logic [FW-1:0]         last_q, last_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  accept;
  logic [NBW-1:0]        nb_clamped;
  logic [DATA_WIDTH-1:0] cur_word;
  logic                  par_bit;
  logic                  last_bit;
  logic                  last_stop;
  logic                  last_frame;

  assign accept     = (state_q == IDLE) && DATA_VALID && (NUM_BYTES != '0);
  assign nb_clamped = (NUM_BYTES > NBW'(MAX_BYTES)) ? NBW'(MAX_BYTES) : NUM_BYTES;
  assign last_bit   = (bit_cnt_q == BW'(DATA_WIDTH-1));
  assign last_stop  = (stop_cnt_q == stop2_q);
  assign last_frame = (frm_q == last_q);

  // Select the word of the frame currently on the line
  always_comb begin
    cur_word = '0;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (frm_q == FW'(k)) cur_word = data_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  uart_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data_i    (cur_word),
    .par_typ_i (par_typ_q),
    .par_bit_o (par_bit)
  );

  // Capture the burst configuration only on accept
  always_comb begin
    data_d    = data_q;
    last_d    = last_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    stop2_d   = stop2_q;
    if (accept) begin
      data_d    = P_DATA;
      last_d    = FW'(nb_clamped - NBW'(1));
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
      stop2_d   = STOP2;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    frm_d      = frm_q;
    stop_cnt_d = stop_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = START;
          frm_d      = '0;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
        end
      end
      START: begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: begin
        if (last_bit) begin
          state_d    = par_en_q ? PARITY : STOP;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      PARITY: begin
        state_d    = STOP;
        stop_cnt_d = 1'b0;
      end
      STOP: begin
        if (last_stop) begin
          stop_cnt_d = 1'b0;
          if (last_frame) begin
            state_d = IDLE;
            frm_d   = '0;
          end else begin
            state_d = START;
            frm_d   = frm_q + FW'(1);
          end
        end else begin
          stop_cnt_d = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        bit_cnt_d  = '0;
        frm_d      = '0;
        stop_cnt_d = 1'b0;
      end
    endcase
  end

  // Registered outputs are decoded from the state being entered
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (state_d == IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_word[bit_cnt_d];
      PARITY:  tx_d = par_bit;
      default: tx_d = 1'b1;
    endcase
  end

  // State, counters and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      frm_q      <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      frm_q      <= frm_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Latched burst configuration
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q    <= '0;
      last_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else begin
      data_q    <= data_d;
      last_q    <= last_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      stop2_q   <= stop2_d;
    end
  end

  assign TX_OUT    = tx_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx (DATA_WIDTH=8, MAX_BYTES=2).
// The model expands each burst into the per-cycle line values
// {TX_OUT, BUSY, DONE}; a compare process checks them every cycle.
module tb_uart_frame_tx;

  localparam int W  = 8;
  localparam int MB = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [MB*W-1:0] p_data = '0;
  logic [1:0]      num_bytes = '0;
  logic            data_valid = 1'b0;
  logic            par_en = 1'b0;
  logic            par_typ = 1'b0;
  logic            stop2 = 1'b0;
  logic            tx_out;
  logic            busy;
  logic            done;
  logic [2:0]      state_dbg;

  // Expected line values per cycle after an accept: {tx, busy, done}
  logic [2:0] exp_q[$];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int busy_total = 0;
  int done_total = 0;

  uart_frame_tx #(
    .DATA_WIDTH (W),
    .MAX_BYTES  (MB)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .P_DATA     (p_data),
    .NUM_BYTES  (num_bytes),
    .DATA_VALID (data_valid),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .STOP2      (stop2),
    .TX_OUT     (tx_out),
    .BUSY       (busy),
    .DONE       (done),
    .STATE_DBG  (state_dbg)
  );

  // Clock
  initial forever #5 clk = ~clk;

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- model ----------------
  function automatic int frame_len(input logic pe, input logic s2);
    return 1 + W + (pe ? 1 : 0) + 1 + (s2 ? 1 : 0);
  endfunction

  // Line value at position idx within one frame
  function automatic logic frame_bit(input logic [W-1:0] word, input logic pe,
                                     input logic pt, input int idx);
    logic par;
    if (idx == 0) return 1'b0;
    if (idx <= W) return word[idx-1];
    if (pe && idx == W + 1) begin
      par = ($countones(word) % 2 == 1) ? 1'b1 : 1'b0;
      return par ^ pt;
    end
    return 1'b1;
  endfunction

  task automatic push_burst(input logic [MB*W-1:0] d, input int nb, input logic pe,
                            input logic pt, input logic s2);
    int n;
    n = (nb > MB) ? MB : nb;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < frame_len(pe, s2); i++) begin
        exp_q.push_back({frame_bit(d[k*W +: W], pe, pt, i), 1'b1, 1'b0});
      end
    end
    exp_q.push_back(3'b101);
  endtask

  // ---------------- checks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Per-cycle compare against the model queue (idle when the queue is empty)
  initial forever begin
    logic [2:0] e;
    @(negedge clk);
    cyc++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b100;
    if (busy === 1'b1) busy_total++;
    if (done === 1'b1) done_total++;
    n_total++;
    if ({tx_out, busy, done} === e) n_pass++;
    else $display("FAIL line cycle %0d {tx,busy,done}: got %b expected %b",
                  cyc, {tx_out, busy, done}, e);
  end

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; entered and left just after a posedge
  task automatic send(input logic [MB*W-1:0] d, input logic [1:0] nb, input logic pe,
                      input logic pt, input logic s2);
    p_data     = d;
    num_bytes  = nb;
    par_en     = pe;
    par_typ    = pt;
    stop2      = s2;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    if (nb != 2'd0) push_burst(d, int'(nb), pe, pt, s2);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check(name, (exp_q.size() == 0) ? 1 : 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [10:0] lit_cd;
    logic [10:0] mdl_cd;
    int b0;
    int d0;

    // Pin the model with hand-computed frames
    lit_cd = 11'b11110011010;
    for (int i = 0; i < 11; i++) mdl_cd[i] = frame_bit(8'hCD, 1'b1, 1'b0, i);
    check("model_cd_frame", mdl_cd, lit_cd);
    check("model_d0_parity", frame_bit(8'hD0, 1'b1, 1'b0, 9), 1);
    check("model_07_parity", frame_bit(8'h07, 1'b1, 1'b0, 9), 1);
    check("model_ae_odd_parity", frame_bit(8'hAE, 1'b1, 1'b1, 9), 0);
    check("model_len_odd_stop2", frame_len(1'b1, 1'b1), 12);
    check("model_len_nopar", frame_len(1'b0, 1'b0), 10);

    // Reset state
    tick(1);
    check("reset_tx", tx_out, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    tick(2);
    rst = 1'b0;
    tick(4);

    // 0xCD, even parity, one stop bit
    b0 = busy_total; d0 = done_total;
    send(16'h00CD, 2'd1, 1'b1, 1'b0, 1'b0);
    wait_idle("t1_drain");
    check("t1_busy_cycles", busy_total - b0, 11);
    check("t1_done_pulses", done_total - d0, 1);

    // Two frames 0xD0 then 0x07, no gap
    b0 = busy_total; d0 = done_total;
    send(16'h07D0, 2'd2, 1'b1, 1'b0, 1'b0);
    wait_idle("t2_drain");
    check("t2_busy_cycles", busy_total - b0, 22);
    check("t2_done_pulses", done_total - d0, 1);

    // Odd parity, two stop bits
    b0 = busy_total; d0 = done_total;
    send(16'h00AE, 2'd1, 1'b1, 1'b1, 1'b1);
    wait_idle("t3_drain");
    check("t3_busy_cycles", busy_total - b0, 12);
    check("t3_done_pulses", done_total - d0, 1);

    // No parity, NUM_BYTES above MAX_BYTES clamps to two frames
    b0 = busy_total; d0 = done_total;
    send(16'h5A3C, 2'd3, 1'b0, 1'b0, 1'b0);
    wait_idle("t4_drain");
    check("t4_busy_cycles", busy_total - b0, 20);
    check("t4_done_pulses", done_total - d0, 1);

    // Request held in the DONE cycle is taken immediately
    b0 = busy_total; d0 = done_total;
    send(16'h0081, 2'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() <= 1) break;
      tick(1);
    end
    check("t5_at_done_cycle", exp_q.size(), 1);
    send(16'h00F0, 2'd1, 1'b0, 1'b1, 1'b1);
    wait_idle("t5_drain");
    check("t5_busy_cycles", busy_total - b0, 22);
    check("t5_done_pulses", done_total - d0, 2);

    // New request and PAR_TYP toggling during a burst are ignored
    b0 = busy_total; d0 = done_total;
    send(16'h0055, 2'd1, 1'b1, 1'b0, 1'b0);
    tick(3);
    data_valid = 1'b1;
    p_data     = 16'hFFFF;
    num_bytes  = 2'd2;
    par_en     = 1'b0;
    stop2      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      par_typ = ~par_typ;
      tick(1);
    end
    data_valid = 1'b0;
    wait_idle("t6_drain");
    check("t6_busy_cycles", busy_total - b0, 11);
    check("t6_done_pulses", done_total - d0, 1);

    // NUM_BYTES=0 request is dropped
    b0 = busy_total; d0 = done_total;
    send(16'h1234, 2'd0, 1'b1, 1'b0, 1'b0);
    tick(5);
    check("t7_busy_cycles", busy_total - b0, 0);
    check("t7_done_pulses", done_total - d0, 0);

    // Reset during DATA of the second frame, then a clean burst
    send(16'h3CC3, 2'd2, 1'b1, 1'b0, 1'b0);
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t8_rst_tx", tx_out, 1);
    check("t8_rst_busy", busy, 0);
    check("t8_rst_done", done, 0);
    exp_q.delete();
    tick(2);
    rst = 1'b0;
    tick(3);
    b0 = busy_total; d0 = done_total;
    send(16'h00A5, 2'd1, 1'b1, 1'b1, 1'b0);
    wait_idle("t8_drain");
    check("t8_busy_cycles", busy_total - b0, 11);
    check("t8_done_pulses", done_total - d0, 1);

    tick(3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
